// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster timing generator driven by a pixel-rate enable strobe.
// Ports:
//   clock        in   system clock
//   reset        in   asynchronous active-high reset
//   pixel_en     in   advance one pixel on each clock edge where high
//   hsync        out  horizontal sync, active level HSYNC_POL
//   vsync        out  vertical sync, active level VSYNC_POL
//   video_on     out  high while (pixel_x,pixel_y) is in the visible area
//   pixel_x      out  horizontal position 0..H_TOTAL-1
//   pixel_y      out  vertical position 0..V_TOTAL-1
//   line_start   out  one-clock pulse after pixel_x is loaded with 0
//   frame_start  out  one-clock pulse after (pixel_x,pixel_y) is loaded with (0,0)
module vga_sync_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CNT_W     = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pixel_en,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             line_start,
    output logic             frame_start
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SS    = H_VISIBLE + H_FRONT;
    localparam int H_SE    = H_SS + H_SYNC;
    localparam int V_SS    = V_VISIBLE + V_FRONT;
    localparam int V_SE    = V_SS + V_SYNC;
    if ((2 ** CNT_W) < H_TOTAL || (2 ** CNT_W) < V_TOTAL) begin : g_cnt_w_too_small
        $error("vga_sync_gen: CNT_W too small for H_TOTAL/V_TOTAL");
    end
    logic [CNT_W-1:0] pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d, video_on_q, video_on_d;
    logic             line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic             x_wrap, y_wrap;
    // Sync and video decode look at the next position so they change on the same edge as the counters.
    always_comb begin
        x_wrap        = pixel_x_q == CNT_W'(H_TOTAL - 1);
        y_wrap        = pixel_y_q == CNT_W'(V_TOTAL - 1);
        pixel_x_d     = pixel_en ? (x_wrap ? '0 : pixel_x_q + CNT_W'(1)) : pixel_x_q;
        pixel_y_d     = (pixel_en && x_wrap) ? (y_wrap ? '0 : pixel_y_q + CNT_W'(1)) : pixel_y_q;
        hsync_d       = pixel_en ? ((pixel_x_d >= CNT_W'(H_SS) && pixel_x_d < CNT_W'(H_SE)) ? HSYNC_POL : ~HSYNC_POL) : hsync_q;
        vsync_d       = pixel_en ? ((pixel_y_d >= CNT_W'(V_SS) && pixel_y_d < CNT_W'(V_SE)) ? VSYNC_POL : ~VSYNC_POL) : vsync_q;
        video_on_d    = pixel_en ? (pixel_x_d < CNT_W'(H_VISIBLE) && pixel_y_d < CNT_W'(V_VISIBLE)) : video_on_q;
        line_start_d  = pixel_en && x_wrap;
        frame_start_d = pixel_en && x_wrap && y_wrap;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pixel_x_q     <= CNT_W'(H_TOTAL - 1);
            pixel_y_q     <= CNT_W'(V_TOTAL - 1);
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            video_on_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end
    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed bench for vga_sync_gen in an 8x6 raster configuration.
module tb_vga_sync_gen;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       pixel_en = 1'b0;
    logic       hsync, vsync, video_on, line_start, frame_start;
    logic [3:0] pixel_x, pixel_y;
    int         n_vec = 0;
    int         n_err = 0;
    int         ex = 7;
    int         ey = 5;
    int         fs_cnt;
    vga_sync_gen #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_W(4)
    ) dut (
        .clock(clock), .reset(reset), .pixel_en(pixel_en),
        .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .line_start(line_start), .frame_start(frame_start)
    );
    always #5 clock = ~clock;
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    // Expected values for the 8x6 raster: hsync low at x=5,6, vsync low at y=4, visible x<4,y<3.
    task automatic chk_all(input bit en);
        chk("pixel_x", 16'(pixel_x), 16'(ex));
        chk("pixel_y", 16'(pixel_y), 16'(ey));
        chk("hsync", 16'(hsync), 16'(!(ex == 5 || ex == 6)));
        chk("vsync", 16'(vsync), 16'(ey != 4));
        chk("video_on", 16'(video_on), 16'(ex < 4 && ey < 3));
        chk("line_start", 16'(line_start), 16'(en && ex == 0));
        chk("frame_start", 16'(frame_start), 16'(en && ex == 0 && ey == 0));
    endtask
    task automatic cyc(input bit en);
        pixel_en = en;
        @(posedge clock);
        #1;
        if (en) begin
            ey = (ex == 7) ? ((ey == 5) ? 0 : ey + 1) : ey;
            ex = (ex == 7) ? 0 : ex + 1;
        end
    endtask
    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk_all(1'b0);
        reset = 1'b0;
        cyc(1'b1);
        chk("t1_x", 16'(pixel_x), 16'h0);
        chk("t1_frame_start", 16'(frame_start), 16'h1);
        chk_all(1'b1);
        cyc(1'b0);
        chk_all(1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1);
            chk_all(1'b1);
            for (int j = 0; j < 3; j++) begin
                cyc(1'b0);
                chk_all(1'b0);
            end
        end
        chk("t2_wrap_x", 16'(pixel_x), 16'h0);
        fs_cnt = 0;
        for (int i = 0; i < 48; i++) begin
            cyc(1'b1);
            chk_all(1'b1);
            fs_cnt += int'(frame_start);
            cyc(1'b0);
        end
        chk("t3_frame_pulses", 16'(fs_cnt), 16'd1);
        fs_cnt = 0;
        pixel_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            cyc(1'b1);
            chk_all(1'b1);
            fs_cnt += int'(frame_start);
        end
        chk("t4_frame_pulses", 16'(fs_cnt), 16'd2);
        chk("t4_pos_x", 16'(pixel_x), 16'd4);
        chk("t4_pos_y", 16'(pixel_y), 16'd1);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0);
            chk_all(1'b0);
        end
        while (!(ex == 6 && ey == 4)) cyc(1'b1);
        chk("t6_pre_hsync", 16'(hsync), 16'h0);
        chk("t6_pre_vsync", 16'(vsync), 16'h0);
        pixel_en = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        ex = 7;
        ey = 5;
        chk("t6_rst_x", 16'(pixel_x), 16'd7);
        chk("t6_rst_y", 16'(pixel_y), 16'd5);
        chk_all(1'b0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        cyc(1'b1);
        chk_all(1'b1);
        chk("t6_after_frame_start", 16'(frame_start), 16'h1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
